// File: rtl/sum_display_driver.sv
// sum_display_driver: shows the synchronized 5-bit adder sum as two decimal digits on a 4-digit seven-segment display.
// A debounced pushbutton toggles between tracking the sum and freezing it.
module sum_display_driver #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_sum,
  input  logic       i_hold,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [3:0] o_an,
  output logic [4:0] o_shown
);
  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [4:0] BLANK = 5'd10;
  localparam logic [4:0] LTR_H = 5'd11;
  typedef enum logic {LIVE, FROZEN} state_t;
  state_t r_state, w_next;
  logic [4:0]    r_sum_s1, r_sum_s2, r_shown;
  logic          r_hold_s1, r_hold_s2, r_db_lvl;
  logic [DW-1:0] r_db_cnt;
  logic [RW-1:0] r_ref;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_dp;
  logic          w_db_done, w_press, w_wrap, w_track, w_frozen;
  logic [1:0]    w_tens;
  logic [4:0]    w_ones, w_code;
  logic [6:0]    w_seg;
  assign w_db_done = (r_hold_s2 != r_db_lvl) && (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w_press   = w_db_done && r_hold_s2;
  assign w_wrap    = r_ref == RW'(REFRESH_DIV - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= LIVE;
    else          r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_press) w_next = (r_state == LIVE) ? FROZEN : LIVE;
  end
  always_comb begin
    w_track  = r_state == LIVE;
    w_frozen = r_state == FROZEN;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum_s1  <= '0;
      r_sum_s2  <= '0;
      r_hold_s1 <= 1'b0;
      r_hold_s2 <= 1'b0;
      r_db_cnt  <= '0;
      r_db_lvl  <= 1'b0;
      r_shown   <= '0;
      r_ref     <= '0;
      r_idx     <= '0;
      r_seg     <= 7'h7F;
      r_an      <= 4'hF;
      r_dp      <= 1'b1;
    end else begin
      r_sum_s1  <= i_sum;
      r_sum_s2  <= r_sum_s1;
      r_hold_s1 <= i_hold;
      r_hold_s2 <= r_hold_s1;
      r_db_cnt  <= (r_hold_s2 == r_db_lvl || w_db_done) ? '0 : r_db_cnt + 1'b1;
      if (w_db_done) r_db_lvl <= r_hold_s2;
      if (w_track)   r_shown  <= r_sum_s2;
      r_ref     <= w_wrap ? '0 : r_ref + 1'b1;
      if (w_wrap)    r_idx    <= r_idx + 1'b1;
      r_seg     <= w_seg;
      r_an      <= ~(4'b0001 << r_idx);
      r_dp      <= 1'b1;
    end
  end
  always_comb begin
    w_tens = (r_shown >= 5'd30) ? 2'd3 : (r_shown >= 5'd20) ? 2'd2 : (r_shown >= 5'd10) ? 2'd1 : 2'd0;
    w_ones = r_shown - 5'd10 * {3'b000, w_tens};
    w_code = (r_idx == 2'd0) ? w_ones :
             (r_idx == 2'd1) ? ((w_tens == 2'd0) ? BLANK : {3'b000, w_tens}) :
             (r_idx == 2'd2) ? BLANK : (w_frozen ? LTR_H : BLANK);
  end
  always_comb begin
    case (w_code)
      5'd0:    w_seg = 7'b1000000;
      5'd1:    w_seg = 7'b1111001;
      5'd2:    w_seg = 7'b0100100;
      5'd3:    w_seg = 7'b0110000;
      5'd4:    w_seg = 7'b0011001;
      5'd5:    w_seg = 7'b0010010;
      5'd6:    w_seg = 7'b0000010;
      5'd7:    w_seg = 7'b1111000;
      5'd8:    w_seg = 7'b0000000;
      5'd9:    w_seg = 7'b0010000;
      LTR_H:   w_seg = 7'b0001001;
      default: w_seg = 7'b1111111;
    endcase
  end
  assign o_seg   = r_seg;
  assign o_an    = r_an;
  assign o_dp    = r_dp;
  assign o_shown = r_shown;
endmodule

// File: tb/tb_sum_display_driver.sv
// tb_sum_display_driver: directed checks of sync latency, BCD/segment decode, scan order, debounce and freeze toggling.
module tb_sum_display_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sum = '0;
  logic       hold = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [4:0] shown;
  int n_chk = 0;
  int n_err = 0;
  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_H     = 7'b0001001;

  sum_display_driver #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sum(sum), .i_hold(hold),
    .o_seg(seg), .o_dp(dp), .o_an(an), .o_shown(shown)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] val);
    for (int i = 0; i < 20; i++) begin
      if (an === val) break;
      @(negedge clk);
    end
    chk("an_wait", an, val);
  endtask

  task automatic seg_at(input string tag, input logic [3:0] a, input logic [6:0] exp);
    wait_an(a);
    chk(tag, seg, exp);
  endtask

  initial begin
    sum  = 5'd19;
    hold = 1'b1;
    cycles(3);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    chk("rst_dp", dp, 1'b1);
    chk("rst_shown", shown, 5'd0);
    hold = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'b1000000);
    // Live tracking and 3-edge latency
    @(negedge clk);
    sum = 5'd22;
    repeat (2) @(posedge clk);
    #1 chk("lat_2edges", shown, 5'd19);
    @(posedge clk);
    #1 chk("lat_3edges", shown, 5'd22);
    cycles(2);
    seg_at("s22_idx0", 4'b1110, 7'b0100100);
    seg_at("s22_idx1", 4'b1101, 7'b0100100);
    seg_at("s22_idx2", 4'b1011, S_BLANK);
    seg_at("s22_idx3", 4'b0111, S_BLANK);
    chk("dp_off", dp, 1'b1);
    // Extremes
    sum = 5'd0;  cycles(4);
    seg_at("s0_idx0", 4'b1110, 7'b1000000);
    seg_at("s0_idx1", 4'b1101, S_BLANK);
    sum = 5'd31; cycles(4);
    chk("s31_shown", shown, 5'd31);
    seg_at("s31_idx0", 4'b1110, 7'b1111001);
    seg_at("s31_idx1", 4'b1101, 7'b0110000);
    sum = 5'd9;  cycles(4);
    seg_at("s9_idx0", 4'b1110, 7'b0010000);
    seg_at("s9_idx1", 4'b1101, S_BLANK);
    // Freeze
    sum = 5'd13; cycles(4);
    hold = 1'b1; cycles(20);
    seg_at("frz_idx3", 4'b0111, S_H);
    seg_at("frz_idx1", 4'b1101, 7'b1111001);
    sum = 5'd7; cycles(6);
    chk("frz_shown", shown, 5'd13);
    hold = 1'b0; cycles(20);
    chk("release_shown", shown, 5'd13);
    seg_at("release_idx3", 4'b0111, S_H);
    hold = 1'b1; cycles(20);
    chk("unfrz_shown", shown, 5'd7);
    seg_at("unfrz_idx3", 4'b0111, S_BLANK);
    hold = 1'b0; cycles(20);
    // Bounce rejection
    for (int i = 0; i < 10; i++) begin
      hold = ~hold;
      cycles(3);
    end
    hold = 1'b0;
    sum = 5'd25; cycles(6);
    chk("bounce_shown", shown, 5'd25);
    seg_at("bounce_idx3", 4'b0111, S_BLANK);
    // Reset mid-FROZEN
    sum = 5'd13; cycles(4);
    hold = 1'b1; cycles(20);
    hold = 1'b0; cycles(20);
    chk("mid_frozen_shown", shown, 5'd13);
    seg_at("mid_frozen_idx3", 4'b0111, S_H);
    wait_an(4'b1011);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_shown", shown, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(4);
    chk("post_rst_shown", shown, 5'd13);
    seg_at("post_rst_idx3", 4'b0111, S_BLANK);
    sum = 5'd4; cycles(4);
    chk("post_rst_track", shown, 5'd4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
